// File: rtl/al_accel_out_quant.sv
// al_accel_out_quant
// ------------------
// Output quantiser behind the accumulation matrix. Each accepted beat carries
// three signed 32-bit channel accumulators. Each lane goes through an optional
// ReLU, a rounding arithmetic right shift, and saturation to signed int8. The
// three bytes are packed into one word, and the word is buffered in a small
// FIFO that feeds the writeback path.
//
// Pipeline: accept -> S1 (ReLU + rounding bias) -> S2 (shift + clamp) -> FIFO.
// A beat accepted at edge k is at the FIFO head after edge k+2 when the FIFO
// was empty.
//
// Ports
//   clk, resetn            clock; synchronous active-low reset
//   enb                    block enable; low freezes every register
//   in_valid / in_ready    accumulator beat handshake
//   in_data_0..2           signed channel accumulators
//   cfg_shift, cfg_relu    per-beat shift amount and ReLU enable, captured at accept
//   out_valid / out_ready  FIFO head handshake
//   out_data               {8'h00, q2, q1, q0}
//   count                  FIFO occupancy
//   sat_flag, sat_clr      sticky saturation flag and its clear
module al_accel_out_quant #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enb,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data_0,
    input  logic [31:0]      in_data_1,
    input  logic [31:0]      in_data_2,
    input  logic [4:0]       cfg_shift,
    input  logic             cfg_relu,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] count,
    output logic             sat_flag,
    input  logic             sat_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    // Applies the ReLU and adds the rounding bias. The sum is 33 bits wide,
    // so adding the bias to 0x7FFFFFFF cannot wrap.
    function automatic logic [32:0] round_bias(input logic [31:0] x,
                                               input logic        relu,
                                               input logic [4:0]  sh);
        logic [32:0] xr;
        logic [32:0] bias;
        xr   = (relu && x[31]) ? 33'd0 : {x[31], x};
        bias = (sh == 5'd0) ? 33'd0 : (33'd1 << (sh - 5'd1));
        return xr + bias;
    endfunction

    // Arithmetic shift followed by an int8 clamp. Bit 8 of the result flags a
    // clamped lane.
    function automatic logic [8:0] quantize(input logic [32:0] r,
                                            input logic [4:0]  sh);
        logic signed [32:0] y;
        y = $signed(r) >>> sh;
        if (y > 33'sd127)
            return {1'b1, 8'h7F};
        else if (y < -33'sd128)
            return {1'b1, 8'h80};
        else
            return {1'b0, y[7:0]};
    endfunction

    // Low from reset until the first enabled edge after reset is released.
    // This holds both handshakes off for one cycle after reset ends.
    logic                  ready_ok;
    logic                  s1_v;
    logic [2:0][32:0]      s1_r;
    logic [4:0]            s1_shift;
    logic                  s2_v;
    logic [2:0][7:0]       s2_q;
    logic [23:0]           mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;

    logic [2:0][31:0]      in_lanes;
    logic [2:0][7:0]       q_next;
    logic                  sat_event;
    logic [CNT_W:0]        occupancy;
    logic                  accept;
    logic                  pop;

    assign in_lanes = {in_data_2, in_data_1, in_data_0};

    // The credit counts beats still in S1/S2, so the FIFO write never has to
    // stall. A pop in the same cycle does not free a slot for this accept.
    assign occupancy = {1'b0, cnt} + {{CNT_W{1'b0}}, s1_v} + {{CNT_W{1'b0}}, s2_v};
    assign in_ready  = enb & ready_ok & (occupancy < DEPTH_C);
    assign out_valid = enb & ready_ok & (cnt != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = {8'h00, mem[rd_ptr]};
    assign count     = cnt;

    // NOTE: every variable in a combinational block is assigned a default
    // first, so no path through the block can leave a latch behind.
    always_comb begin
        logic [8:0] lane;
        q_next    = '0;
        sat_event = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lane      = quantize(s1_r[i], s1_shift);
            q_next[i] = lane[7:0];
            sat_event = sat_event | (s1_v & lane[8]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_ok <= 1'b0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else if (enb) begin
            ready_ok <= 1'b1;
            s1_v     <= accept;
            s2_v     <= s1_v;
            if (s2_v)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({s2_v, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            // When set and clear land on the same edge, the set wins.
            if (sat_event)
                sat_flag <= 1'b1;
            else if (sat_clr)
                sat_flag <= 1'b0;
        end
    end

    // NOTE: the data registers and FIFO storage have no reset. Their contents
    // only matter when the matching valid bit or count says so, and those are
    // reset.
    always_ff @(posedge clk) begin
        if (enb) begin
            if (accept) begin
                for (int i = 0; i < 3; i++)
                    s1_r[i] <= round_bias(in_lanes[i], cfg_relu, cfg_shift);
                s1_shift <= cfg_shift;
            end
            if (s1_v)
                s2_q <= q_next;
            if (s2_v)
                mem[wr_ptr] <= {s2_q[2], s2_q[1], s2_q[0]};
        end
    end

endmodule

// File: tb/tb_al_accel_out_quant.sv
// Self-checking bench for al_accel_out_quant.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled
// on the falling edge. A monitor pushes the model's result for every accepted
// beat and compares each popped word in FIFO order.
module tb_al_accel_out_quant;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             resetn;
    logic             enb;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data_0;
    logic [31:0]      in_data_1;
    logic [31:0]      in_data_2;
    logic [4:0]       cfg_shift;
    logic             cfg_relu;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] count;
    logic             sat_flag;
    logic             sat_clr;

    al_accel_out_quant #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enb       (enb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data_0 (in_data_0),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .sat_flag  (sat_flag),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_popped = 0;
    int          next_idx = 1;
    logic [31:0] sb [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model: a 64-bit integer version of ReLU, round, shift and clamp.
    function automatic logic [7:0] model_lane(input logic [31:0] x, input int sh, input bit relu);
        longint v;
        v = longint'($signed(x));
        if (relu && v < 0) v = 0;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input int sh, input bit relu);
        return {8'h00, model_lane(c, sh, relu), model_lane(b, sh, relu), model_lane(a, sh, relu)};
    endfunction

    // Scoreboard monitor. Inputs are stable at the falling edge, so an accept or
    // pop seen here is exactly what the next rising edge commits.
    always @(negedge clk) begin
        if (!resetn) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_popped++;
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0)
                    check("fifo_out", out_data, sb.pop_front());
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_data_0, in_data_1, in_data_2, int'(cfg_shift), cfg_relu));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input int idx);
        in_data_0 = 32'(idx * 37 - 50);
        in_data_1 = 32'(-idx * 1000);
        in_data_2 = 32'(idx) << 20;
        cfg_shift = 5'(idx % 8);
        cfg_relu  = idx[0];
    endtask

    // Holds in_valid high until n beats are accepted or the budget runs out.
    task automatic feed(input int n, input int budget, output int acc);
        logic ok;
        acc = 0;
        while (acc < n && budget > 0) begin
            gen(next_idx);
            in_valid = 1'b1;
            @(negedge clk);
            ok = in_ready;
            step();
            if (ok) begin
                acc++;
                next_idx++;
            end
            budget--;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [4:0] sh, input logic rl);
        logic ok;
        int   budget;
        ok = 1'b0;
        budget = 20;
        in_data_0 = a; in_data_1 = b; in_data_2 = c;
        cfg_shift = sh; cfg_relu = rl;
        in_valid = 1'b1;
        while (!ok && budget > 0) begin
            @(negedge clk);
            ok = in_ready;
            step();
            budget--;
        end
        in_valid = 1'b0;
        check("accept", 32'(ok), 32'd1);
    endtask

    // Called right after the accepting edge k; samples the head after edge k+2.
    task automatic expect_head(input string tag, input logic [31:0] exp);
        step();
        step();
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, out_data, exp);
    endtask

    task automatic wait_drain(input int budget);
        while ((sb.size() != 0 || count != '0) && budget > 0) begin
            step();
            budget--;
        end
        @(negedge clk);
        check("drain_count", 32'(count), 32'd0);
        check("drain_sb", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_clr();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        @(negedge clk);
        check("sat_cleared", 32'(sat_flag), 32'd0);
    endtask

    initial begin
        int acc;
        int popped0;
        resetn = 1'b0; enb = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
        in_data_0 = '0; in_data_1 = '0; in_data_2 = '0; cfg_shift = '0; cfg_relu = 1'b0;

        // Reset and release
        repeat (3) step();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("rel_ready_c1", 32'(in_ready), 32'd0);
        check("rel_valid_c1", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("rel_ready_c2", 32'(in_ready), 32'd1);

        // Rounding, single beat, with latency checks
        step();
        send_one(32'd40, -32'sd40, 32'd23, 5'd4, 1'b0);
        @(negedge clk);
        check("lat_k0", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("lat_k1", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("round_valid", 32'(out_valid), 32'd1);
        check("round_data", out_data, 32'h0001FE03);
        check("round_sat", 32'(sat_flag), 32'd0);
        out_ready = 1'b1;
        step();
        wait_drain(20);

        // Saturation, then sat_clr alone, then sat_clr on the edge of a new saturating beat
        step();
        send_one(32'd300, -32'sd300, 32'd127, 5'd0, 1'b0);
        expect_head("sat", 32'h007F807F);
        wait_drain(20);
        check("sat_set", 32'(sat_flag), 32'd1);
        step();
        pulse_clr();
        step();
        send_one(32'd300, -32'sd300, 32'd127, 5'd0, 1'b0);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        @(negedge clk);
        check("sat_set_wins", 32'(sat_flag), 32'd1);
        wait_drain(20);

        // ReLU and rounding at the top of the input range
        step();
        pulse_clr();
        step();
        send_one(-32'sd5, 32'd5, 32'h7FFFFFFF, 5'd1, 1'b1);
        expect_head("relu", 32'h007F0300);
        check("relu_sat", 32'(sat_flag), 32'd1);
        wait_drain(20);

        // Backpressure
        out_ready = 1'b0;
        step();
        popped0 = n_popped;
        feed(8, 12, acc);
        check("bp_accepted", 32'(acc), 32'd4);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_count", 32'(count), 32'd4);
        step();
        out_ready = 1'b1;
        feed(4, 40, acc);
        check("bp_rest", 32'(acc), 32'd4);
        wait_drain(40);
        check("bp_popped", 32'(n_popped - popped0), 32'd8);

        // Freeze with 2 beats in flight and 2 buffered
        out_ready = 1'b0;
        step();
        popped0 = n_popped;
        feed(4, 10, acc);
        check("frz_accepted", 32'(acc), 32'd4);
        enb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz_valid", 32'(out_valid), 32'd0);
            check("frz_ready", 32'(in_ready), 32'd0);
            check("frz_count", 32'(count), 32'd2);
            step();
        end
        enb = 1'b1;
        step();
        step();
        @(negedge clk);
        check("frz_resume_count", 32'(count), 32'd4);
        step();
        out_ready = 1'b1;
        wait_drain(40);
        check("frz_popped", 32'(n_popped - popped0), 32'd4);

        // Reset mid-stream
        out_ready = 1'b0;
        step();
        feed(4, 10, acc);
        check("rst_mid_accepted", 32'(acc), 32'd4);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        step();
        out_ready = 1'b1;
        popped0 = n_popped;
        repeat (8) step();
        @(negedge clk);
        check("rst_no_stale", 32'(n_popped - popped0), 32'd0);
        check("rst_stale_count", 32'(count), 32'd0);
        step();
        feed(3, 20, acc);
        check("rst_resume", 32'(acc), 32'd3);
        wait_drain(40);
        check("rst_resume_popped", 32'(n_popped - popped0), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/al_accel_out_quant.md
Name: al_accel_out_quant

Overview:
- Downstream of the accumulation matrix. Consumes the three signed 32-bit channel accumulators once a tile's accumulation is finished.
- Per channel: optional ReLU, then rounding arithmetic right shift, then saturation to signed int8.
- Packs the three bytes into one 32-bit word and buffers it in a small FIFO. The FIFO feeds the output writeback path over a valid/ready handshake.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, >=2).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- enb  input  1  block enable; when low, all state is frozen.
- in_valid  input  1  accumulator beat valid.
- in_ready  output  1  block can accept a beat.
- in_data_0  input  32  signed channel-0 accumulator.
- in_data_1  input  32  signed channel-1 accumulator.
- in_data_2  input  32  signed channel-2 accumulator.
- cfg_shift  input  5  right-shift amount, 0..31.
- cfg_relu  input  1  1 = clamp negative inputs to 0 before rounding.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_data  output  32  {8'h00, q2, q1, q0}.
- count  output  CNT_W  FIFO occupancy.
- sat_flag  output  1  sticky flag: a saturation has occurred.
- sat_clr  input  1  clears sat_flag.

Behaviour:
- Reset (resetn=0 at an edge):
  - S1/S2 valid bits, FIFO pointers and count are cleared; sat_flag=0.
  - in_ready=0 and out_valid=0 while resetn=0 and through the following cycle.
  - out_data is don't-care while out_valid=0.
  - Reset mid-operation discards all in-flight and buffered beats.
- Gating:
  - in_ready = enb & (count + s1_v + s2_v < DEPTH).
  - out_valid = enb & (count != 0).
  - enb=0 freezes every register, including sat_flag.
- Accept: in_valid & in_ready at edge k loads S1 with the three inputs, plus cfg_shift and cfg_relu captured for that beat. Later config changes do not affect beats already in flight.
- Stage S1, registered:
  - x' = (cfg_relu & x<0) ? 0 : x.
  - r = sext33(x') + (shift==0 ? 0 : 1<<(shift-1)).
  - r is computed in 33 bits, so it never overflows.
- Stage S2, registered:
  - y = r >>> shift (arithmetic).
  - q = y>127 ? 8'h7F : y<-128 ? 8'h80 : y[7:0].
  - A saturate event is any lane clamped on a valid S2 load.
- FIFO write: the S2 beat is written unconditionally on the edge after S2 loads.
  - Credit check at accept guarantees space, so FIFO write never stalls the pipeline.
  - A beat accepted at edge k is at the FIFO head with out_valid=1 after edge k+2, provided the FIFO was empty.
- Pop: out_valid & out_ready at an edge advances the read pointer.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Ordering is strictly FIFO; no beat is lost or duplicated.
- Credit is conservative: a same-cycle pop does not free a slot for the same-cycle accept.
- sat_flag:
  - Set on a saturate event; cleared by sat_clr.
  - If set and clear occur on the same edge, set wins.
- Throughput: one beat per cycle when out_ready is held high.

Test Plan:
1. Reset:
   - Hold resetn=0 for 3 cycles -> in_ready=0, out_valid=0, count=0, sat_flag=0.
   - With enb=1 after release -> in_ready=1 on the second cycle after release.
2. Rounding, single beat:
   - Stimulus: shift=4, relu=0, inputs (40, -40, 23), accepted at edge k.
   - Required: out_valid=1 after edge k+2, out_data=0x0001FE03, sat_flag=0.
3. Saturation:
   - Stimulus: shift=0, inputs (300, -300, 127).
   - Required: out_data=0x007F807F, sat_flag=1.
   - sat_clr pulse -> sat_flag=0 next edge.
   - sat_clr on the same edge as a new saturating beat -> sat_flag stays 1.
4. ReLU and rounding edge:
   - Stimulus: relu=1, shift=1, inputs (-5, 5, 0x7FFFFFFF).
   - Required: out_data=0x007F0300, sat_flag=1, no wrap.
5. Backpressure:
   - Stimulus: DEPTH=4, out_ready=0, in_valid held high with beats 1..8.
   - Required: exactly 4 beats accepted, then in_ready=0 with count=4.
   - Raise out_ready: 8 beats emerge in order, count returns to 0, no duplicates.
6. Freeze and reset mid-stream:
   - enb=0 with 2 beats in flight and 2 buffered -> all state holds, out_valid=0.
   - enb=1 -> stream resumes intact.
   - Repeat, but pulse resetn=0 instead -> count=0, out_valid=0, and no stale beat ever appears.
